// File: rtl/write_buffer.sv
// write_buffer: posted-write FIFO between the data cache write-through port
// and data memory. Writes are acknowledged as soon as they are queued and are
// drained to memory in order; a read miss goes to memory only after every
// earlier write has drained. The memory-side FSM always returns to IDLE
// between transactions, so mem_write and mem_read_miss are never both high.
module write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     Clk,
  input  logic                     Rst,
  // cache write-through side
  input  logic                     wr_req,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data,
  output logic                     wr_ack,
  // cache read-miss side
  input  logic                     rd_req,
  input  logic [AW-1:0]            rd_addr,
  output logic                     rd_ready,
  // data memory side
  output logic [AW-1:0]            mem_address,
  output logic                     mem_write,
  output logic [DW-1:0]            mem_write_data,
  output logic                     mem_read_miss,
  input  logic                     mem_write_ready,
  input  logic                     mem_read_ready,
  // occupancy
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10
  } state_e;

  // FIFO storage and bookkeeping
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // control
  state_e        state_q, state_d;
  logic          wr_ack_q, wr_ack_d;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;

  // registered memory-side outputs, computed from the next state
  logic          mem_write_q, mem_write_d;
  logic          mem_read_miss_q, mem_read_miss_d;
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic [DW-1:0] mem_write_data_q, mem_write_data_d;

  // Occupancy flags come straight from the registered count, so a pop in the
  // same cycle never opens room for a push.
  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});

  // A push is taken once per request; the ack cycle itself is blocked so a
  // requester still holding wr_req while it sees the ack is not queued twice.
  assign push_s = wr_req & ~full_s & ~wr_ack_q;

  // The head entry leaves the FIFO when memory completes the write.
  assign pop_s  = (state_q == WRITE) & mem_write_ready & ~empty_s;

  // Next-state logic for pointers, count and write acknowledge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_ack_d = push_s;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Memory-side FSM: next state plus the output values for that next state.
  always_comb begin
    state_d          = state_q;
    mem_write_d      = 1'b0;
    mem_read_miss_d  = 1'b0;
    mem_address_d    = {AW{1'b0}};
    mem_write_data_d = {DW{1'b0}};

    case (state_q)
      IDLE: begin
        // Pending writes always go first so reads never bypass them.
        if (!empty_s) begin
          state_d = WRITE;
        end else if (rd_req) begin
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (mem_write_ready) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      READ: begin
        if (mem_read_ready) begin
          state_d = IDLE;
        end else begin
          state_d = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The head slot cannot be overwritten while it is being drained: pushes
    // target wr_ptr, which differs from rd_ptr whenever the FIFO is not empty
    // and not full, and a full FIFO accepts no pushes.
    case (state_d)
      WRITE: begin
        mem_write_d      = 1'b1;
        mem_address_d    = addr_q[rd_ptr_d];
        mem_write_data_d = data_q[rd_ptr_d];
      end
      READ: begin
        mem_read_miss_d  = 1'b1;
        mem_address_d    = rd_addr;
      end
      default: begin
        mem_write_d      = 1'b0;
        mem_read_miss_d  = 1'b0;
      end
    endcase
  end

  // State, pointer, count and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q          <= IDLE;
      wr_ptr_q         <= {PW{1'b0}};
      rd_ptr_q         <= {PW{1'b0}};
      count_q          <= {CW{1'b0}};
      wr_ack_q         <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_read_miss_q  <= 1'b0;
      mem_address_q    <= {AW{1'b0}};
      mem_write_data_q <= {DW{1'b0}};
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      wr_ack_q         <= wr_ack_d;
      mem_write_q      <= mem_write_d;
      mem_read_miss_q  <= mem_read_miss_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  // FIFO entry storage: cleared on reset, written at wr_ptr on each push.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {AW{1'b0}};
        data_q[i] <= {DW{1'b0}};
      end
    end else if (push_s) begin
      addr_q[wr_ptr_q] <= wr_addr;
      data_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ack         = wr_ack_q;
  assign mem_write      = mem_write_q;
  assign mem_read_miss  = mem_read_miss_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  // The fill is a pass-through of the memory's valid while the read is open.
  assign rd_ready       = (state_q == READ) & mem_read_ready;
  assign full           = full_s;
  assign empty          = empty_s;
  assign count          = count_q;

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: a small memory model answers writes and
// reads after a programmable latency, and a scoreboard queue of expected
// writes is checked in issue order whenever memory completes one.
module tb_write_buffer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ready;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic        mem_read_miss;
  logic        mem_write_ready = 1'b0;
  logic        mem_read_ready  = 1'b0;
  logic        full;
  logic        empty;
  logic [2:0]  count;

  write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ack          (wr_ack),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_ready        (rd_ready),
    .mem_address     (mem_address),
    .mem_write       (mem_write),
    .mem_write_data  (mem_write_data),
    .mem_read_miss   (mem_read_miss),
    .mem_write_ready (mem_write_ready),
    .mem_read_ready  (mem_read_ready),
    .full            (full),
    .empty           (empty),
    .count           (count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic        mem_en  = 1'b1;
  int          wr_lat  = 0;
  int          rd_lat  = 0;
  int          wcnt    = 0;
  int          rcnt    = 0;
  logic [31:0] exp_rd_addr = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to a point safely after the falling edge.
  task automatic cyc();
    @(negedge Clk);
    #2;
  endtask

  // Issue one write, queue its expectation, and wait (bounded) for the ack.
  task automatic push_write(input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    logic got;
    e.a = a;
    e.d = d;
    sb.push_back(e);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (wr_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("wr_ack_seen", got, 1'b1);
    wr_req = 1'b0;
  endtask

  // Wait (bounded) until the buffer is empty and memory is idle.
  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (empty && !mem_write && !mem_read_miss) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", done, 1'b1);
    chk("sb_empty_after_drain", sb.size(), 0);
  endtask

  // Memory write side: ready after wr_lat extra cycles while enabled.
  always @(negedge Clk) begin
    if (Rst || !mem_en || !mem_write) begin
      wcnt            <= 0;
      mem_write_ready <= 1'b0;
    end else if (wcnt >= wr_lat) begin
      wcnt            <= 0;
      mem_write_ready <= 1'b1;
    end else begin
      wcnt            <= wcnt + 1;
      mem_write_ready <= 1'b0;
    end
  end

  // Memory read side: ready after rd_lat extra cycles.
  always @(negedge Clk) begin
    if (Rst || !mem_read_miss) begin
      rcnt           <= 0;
      mem_read_ready <= 1'b0;
    end else if (rcnt >= rd_lat) begin
      rcnt           <= 0;
      mem_read_ready <= 1'b1;
    end else begin
      rcnt           <= rcnt + 1;
      mem_read_ready <= 1'b0;
    end
  end

  // Monitor: ordering of completed writes, read address, fill mirror, bounds.
  always @(negedge Clk) begin
    #1;
    if (!Rst) begin
      chk("mem_mutex", {1'b0, mem_write & mem_read_miss}, 2'b00);
      chk("count_le_depth", (count <= 3'd4), 1'b1);
      if (mem_write && mem_write_ready) begin
        chk("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          chk("mem_wr_addr", mem_address, sb[0].a);
          chk("mem_wr_data", mem_write_data, sb[0].d);
          void'(sb.pop_front());
        end
      end
      if (mem_read_miss) begin
        chk("mem_rd_addr", mem_address, exp_rd_addr);
        chk("rd_ready_mirror", rd_ready, mem_read_ready);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    Rst = 1'b1; wr_req = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
    rd_req = 1'b0; rd_addr = 32'h0;

    // 1: reset state
    cyc(); cyc();
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_wr_ack", wr_ack, 1'b0);
    chk("rst_mem_read_miss", mem_read_miss, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    Rst = 1'b0;
    cyc();

    // 2: single write, memory answers three cycles after mem_write
    mem_en = 1'b1; wr_lat = 2;
    sb.push_back('{a: 32'h100, d: 32'hDEADBEEF});
    wr_req = 1'b1; wr_addr = 32'h100; wr_data = 32'hDEADBEEF;
    cyc();
    chk("t2_ack_pulse", wr_ack, 1'b1);
    chk("t2_count1", count, 3'd1);
    chk("t2_not_empty", empty, 1'b0);
    chk("t2_no_write_yet", mem_write, 1'b0);
    wr_req = 1'b0;
    cyc();
    chk("t2_ack_low", wr_ack, 1'b0);
    chk("t2_mem_write", mem_write, 1'b1);
    chk("t2_addr", mem_address, 32'h100);
    chk("t2_data", mem_write_data, 32'hDEADBEEF);
    cyc();
    chk("t2_write_held", mem_write, 1'b1);
    cyc();
    chk("t2_write_held2", mem_write, 1'b1);
    chk("t2_data_held", mem_write_data, 32'hDEADBEEF);
    cyc();
    chk("t2_write_done", mem_write, 1'b0);
    chk("t2_empty", empty, 1'b1);
    chk("t2_sb_empty", sb.size(), 0);

    // 3: fill with memory stalled, fifth write waits for space
    mem_en = 1'b0; wr_lat = 0;
    for (int i = 0; i < 4; i++) push_write(32'h1000 + 32'(i), 32'hA000 + 32'(i));
    cyc();
    chk("t3_count4", count, 3'd4);
    chk("t3_full", full, 1'b1);
    sb.push_back('{a: 32'h1004, d: 32'hA004});
    wr_req = 1'b1; wr_addr = 32'h1004; wr_data = 32'hA004;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_ack_withheld", wr_ack, 1'b0);
      chk("t3_full_held", full, 1'b1);
    end
    mem_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (wr_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("t3_fifth_ack", got, 1'b1);
    wr_req = 1'b0;
    drain();

    // 4: read after write waits for the write to drain
    wr_lat = 2; rd_lat = 1;
    push_write(32'h200, 32'h5);
    rd_req = 1'b1; rd_addr = 32'h200; exp_rd_addr = 32'h200;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (mem_read_miss) begin
        got = 1'b1;
        break;
      end
    end
    chk("t4_miss_seen", got, 1'b1);
    chk("t4_write_drained_first", sb.size(), 0);
    chk("t4_miss_addr", mem_address, 32'h200);
    chk("t4_no_write_during_read", mem_write, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (rd_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("t4_rd_ready", got, 1'b1);
    rd_req = 1'b0;
    cyc();
    chk("t4_miss_low", mem_read_miss, 1'b0);
    chk("t4_rd_ready_low", rd_ready, 1'b0);

    // 4b: empty buffer, read miss one cycle after request
    rd_lat = 0;
    rd_req = 1'b1; rd_addr = 32'h300; exp_rd_addr = 32'h300;
    cyc();
    chk("t4b_miss_latency", mem_read_miss, 1'b1);
    chk("t4b_addr", mem_address, 32'h300);
    chk("t4b_rd_ready", rd_ready, 1'b1);
    rd_req = 1'b0;
    cyc();
    chk("t4b_miss_low", mem_read_miss, 1'b0);

    // 5: wrap pointers with memory always ready
    wr_lat = 0;
    for (int i = 0; i < 10; i++) push_write(32'h400 + 32'(4 * i), 32'(i));
    drain();

    // 6: reset while writing with three entries queued
    mem_en = 1'b0;
    for (int i = 0; i < 3; i++) push_write(32'h600 + 32'(i), 32'hB0 + 32'(i));
    cyc();
    chk("t6_count3", count, 3'd3);
    chk("t6_in_write", mem_write, 1'b1);
    Rst = 1'b1;
    sb.delete();
    cyc();
    chk("t6_mem_write_cleared", mem_write, 1'b0);
    chk("t6_count_cleared", count, 3'd0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_wr_ack", wr_ack, 1'b0);
    Rst = 1'b0;
    mem_en = 1'b1;
    cyc();
    push_write(32'h700, 32'hA5A5A5A5);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
